// File: rtl/dsa_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding, width helper
// and the single-bit full-adder cell used by the digit ripple.
package dsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Returns {carry_out, sum} of x + y + c.
  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple of full-adder cells. c_top is the carry
// into the most significant bit of the digit, used for signed overflow.
module digit_adder
  import dsa_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_top
);

  // Ripple carry through the digit.
  always_comb begin
    logic [DIGIT:0] c_v;
    logic [1:0]     fa_v;
    c_v    = '0;
    fa_v   = 2'b00;
    s      = '0;
    c_v[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      fa_v       = full_adder(a[i], b[i], c_v[i]);
      s[i]       = fa_v[0];
      c_v[i + 1] = fa_v[1];
    end
    co    = c_v[DIGIT];
    c_top = c_v[DIGIT-1];
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit add, DIGIT bits per clock, LSB digit first.
// Define DSA_SUB_EN to add the sub port (a - b via inverted b and carry-in 1).
module digit_serial_adder
  import dsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

  state_t             state_r;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [WIDTH-1:0]   b_sel_s;
  logic               c_seed_s;
  logic [DIGIT-1:0]   d_sum_s;
  logic               d_co_s;
  logic               d_ctop_s;

  // Operand B and carry seed chosen at accept time.
  always_comb begin
    b_sel_s  = b;
    c_seed_s = cin;
`ifdef DSA_SUB_EN
    if (sub) begin
      b_sel_s  = ~b;
      c_seed_s = 1'b1;
    end else begin
      b_sel_s  = b;
      c_seed_s = cin;
    end
`endif
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sh_r[DIGIT-1:0]),
    .b     (b_sh_r[DIGIT-1:0]),
    .ci    (carry_r),
    .s     (d_sum_s),
    .co    (d_co_s),
    .c_top (d_ctop_s)
  );

  // Control FSM, operand shifters, carry register and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      cnt_r     <= '0;
      carry_r   <= 1'b0;
      a_sh_r    <= '0;
      b_sh_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh_r   <= a;
            b_sh_r   <= b_sel_s;
            carry_r  <= c_seed_s;
            cnt_r    <= '0;
            in_ready <= 1'b0;
            state_r  <= RUN;
          end
        end
        RUN: begin
          a_sh_r  <= a_sh_r >> DIGIT;
          b_sh_r  <= b_sh_r >> DIGIT;
          carry_r <= d_co_s;
          for (int k = 0; k < NDIG; k++) begin
            if (cnt_r == CNT_W'(k)) sum[k*DIGIT +: DIGIT] <= d_sum_s;
          end
          if (cnt_r == CNT_W'(NDIG - 1)) begin
            cnt_r   <= '0;
            cout    <= d_co_s;
            ovf     <= d_co_s ^ d_ctop_s;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          // One settling cycle before presenting the result, then hold it.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder (WIDTH=8, DIGIT=2 by default).
module tb_digit_serial_adder;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef DSA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               acc;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic pv_valid = 1'b0;
  logic pv_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops on out_valid rise, then checks hold and release behaviour.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_valid = 1'b0;
      pv_ready = 1'b0;
    end else begin
      if (out_valid && !pv_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          held = q.pop_front();
          chk("sum", 32'(sum), 32'(held.sum));
          chk("cout", 32'(cout), 32'(held.cout));
          chk("ovf", 32'(ovf), 32'(held.ovf));
          chk("latency", 32'(cyc - held.acc), 32'(NDIG + 1));
          chk("in_ready_done", 32'(in_ready), 32'd0);
        end
      end else if (out_valid && pv_valid) begin
        chk("hold_sum", 32'(sum), 32'(held.sum));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end else if (!out_valid && pv_valid) begin
        chk("drop_needs_ready", 32'(pv_ready), 32'd1);
        chk("release_in_ready", 32'(in_ready), 32'd1);
      end
      pv_valid = out_valid;
      pv_ready = out_ready;
    end
  end

  task automatic do_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts, input logic [7:0] es, input logic ec,
                        input logic eo, input bit push);
    int t;
    exp_t e;
    t = 0;
    @(posedge clk);
    #1;
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) chk("accept_timeout", 32'(t), 32'd0);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[7] = '{
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
    '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
    '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0},
    '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0}
  };

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b1);
      drain();
    end

    // Consumer stalls for 10 cycles in DONE.
    out_ready = 1'b0;
    do_add(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (!out_valid) chk("stall_timeout", 32'(out_valid), 32'd1);
    end
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset during the third digit drops the add.
    do_add(8'h55, 8'h22, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_add(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    drain();

    // New operands offered during RUN must be ignored.
    do_add(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

`ifdef DSA_SUB_EN
    do_add(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
    drain();
    do_add(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
